// File: rtl/cam_fifo_pkg.sv
// Shared state encoding and default frame/timing geometry for the AL422B
// camera FIFO controller.
package cam_fifo_pkg;

  localparam int unsigned FRAME_BYTES_DEF = 32'd153600;
  localparam int unsigned RCLK_HALF_DEF   = 32'd2;
  localparam int unsigned RRST_CYCLES_DEF = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CAP_WAIT1 = 3'd1,
    ST_CAP_WRST  = 3'd2,
    ST_CAP_WAIT2 = 3'd3,
    ST_RD_RRST   = 3'd4,
    ST_RD_WAIT   = 3'd5,
    ST_RD_HIGH   = 3'd6,
    ST_RD_LOW    = 3'd7
  } cam_state_e;

endpackage

// File: rtl/cam_vsync_sync.sv
// Two-flop synchroniser for the camera VSYNC plus rising/falling edge
// detection on the synchronised level.
module cam_vsync_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_vsync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // synchroniser chain plus one delayed copy for edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_vsync;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/cam_fifo_ctrl.sv
// AL422B frame FIFO controller: VSYNC-framed capture (write reset / write
// enable) and byte-by-byte readout with read-pointer reset and RCLK generation.
module cam_fifo_ctrl
  import cam_fifo_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int unsigned RCLK_HALF   = RCLK_HALF_DEF,
  parameter int unsigned RRST_CYCLES = RRST_CYCLES_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_capture_start,
  input  logic       i_read_start,
  input  logic       i_rd_byte_str,
  input  logic       i_cam_vsync,
  input  logic [7:0] i_fifo_d,
  output logic       o_fifo_busy,
  output logic       o_rrst_done,
  output logic       o_data_ready,
  output logic [7:0] o_data,
  output logic       o_fifo_wrst_n,
  output logic       o_fifo_wen,
  output logic       o_fifo_rrst_n,
  output logic       o_fifo_rclk,
  output logic       o_fifo_oe_n
);

  localparam int unsigned CW = $clog2(FRAME_BYTES + 32'd1);
  localparam int unsigned HW = $clog2(RCLK_HALF + 32'd1);
  localparam int unsigned PW = $clog2(RRST_CYCLES + 32'd1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_BYTES - 32'd1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(FRAME_BYTES);
  localparam logic [HW-1:0] HALF_LAST = HW'(RCLK_HALF - 32'd1);
  localparam logic [PW-1:0] PER_LAST  = PW'(RRST_CYCLES - 32'd1);

  cam_state_e    r_state, w_state_nxt;
  logic [HW-1:0] r_half, w_half_nxt;
  logic          r_hi, w_hi_nxt;
  logic [PW-1:0] r_per, w_per_nxt;
  logic [CW-1:0] r_byte_cnt;

  logic w_vs_rise, w_vs_fall, w_half_end;
  logic w_dr_nxt, w_done_nxt, w_rrst_end, w_is_rd_nxt, w_data_cap;
  logic w_busy_nxt, w_oe_n_nxt, w_rclk_nxt, w_wrst_n_nxt, w_wen_nxt, w_rrst_n_nxt;

  logic       r_busy, r_rrst_done, r_data_ready, r_wrst_n, r_wen, r_rrst_n, r_rclk, r_oe_n;
  logic [7:0] r_data;

  cam_vsync_sync u_vsync_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_vsync (i_cam_vsync),
    .o_rise  (w_vs_rise),
    .o_fall  (w_vs_fall)
  );

  // next-state, half-period/period counters and next values of every output
  always_comb begin
    w_state_nxt = r_state;
    w_half_nxt  = r_half;
    w_hi_nxt    = r_hi;
    w_per_nxt   = r_per;
    w_half_end  = (r_half == HALF_LAST);
    case (r_state)
      ST_IDLE: begin
        if (i_capture_start) begin
          w_state_nxt = ST_CAP_WAIT1;
        end else if (i_read_start) begin
          w_state_nxt = ST_RD_RRST;
          w_half_nxt  = {HW{1'b0}};
          w_hi_nxt    = 1'b1;
          w_per_nxt   = {PW{1'b0}};
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CAP_WAIT1: begin
        if (w_vs_rise) w_state_nxt = ST_CAP_WRST;
        else           w_state_nxt = ST_CAP_WAIT1;
      end
      ST_CAP_WRST: begin
        if (w_vs_fall) w_state_nxt = ST_CAP_WAIT2;
        else           w_state_nxt = ST_CAP_WRST;
      end
      ST_CAP_WAIT2: begin
        if (w_vs_rise) w_state_nxt = ST_IDLE;
        else           w_state_nxt = ST_CAP_WAIT2;
      end
      ST_RD_RRST: begin
        // each RCLK period is a high half then a low half; leave after a low half
        if (!w_half_end) begin
          w_half_nxt = r_half + 1'b1;
        end else begin
          w_half_nxt = {HW{1'b0}};
          if (r_hi) begin
            w_hi_nxt = 1'b0;
          end else if (r_per == PER_LAST) begin
            w_state_nxt = ST_RD_WAIT;
          end else begin
            w_per_nxt = r_per + 1'b1;
            w_hi_nxt  = 1'b1;
          end
        end
      end
      ST_RD_WAIT: begin
        if (i_rd_byte_str) begin
          w_state_nxt = ST_RD_HIGH;
          w_half_nxt  = {HW{1'b0}};
          w_hi_nxt    = 1'b1;
        end else begin
          w_state_nxt = ST_RD_WAIT;
        end
      end
      ST_RD_HIGH: begin
        if (w_half_end) begin
          w_state_nxt = ST_RD_LOW;
          w_half_nxt  = {HW{1'b0}};
          w_hi_nxt    = 1'b0;
        end else begin
          w_half_nxt = r_half + 1'b1;
        end
      end
      ST_RD_LOW: begin
        if (w_half_end) begin
          w_half_nxt = {HW{1'b0}};
          if (r_byte_cnt == CNT_MAX) w_state_nxt = ST_IDLE;
          else                       w_state_nxt = ST_RD_WAIT;
        end else begin
          w_half_nxt = r_half + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // outputs are registered, so decode them from the state about to be entered
    w_dr_nxt     = (w_state_nxt == ST_RD_LOW) && (w_half_nxt == HALF_LAST);
    w_done_nxt   = w_dr_nxt && (r_byte_cnt == CNT_LAST);
    w_rrst_end   = (r_state == ST_RD_RRST) && (w_state_nxt == ST_RD_WAIT);
    w_data_cap   = (r_state == ST_RD_HIGH) && w_half_end;
    w_is_rd_nxt  = (w_state_nxt == ST_RD_RRST) || (w_state_nxt == ST_RD_WAIT) ||
                   (w_state_nxt == ST_RD_HIGH) || (w_state_nxt == ST_RD_LOW);
    w_busy_nxt   = (w_state_nxt != ST_IDLE) && !w_done_nxt;
    w_oe_n_nxt   = !w_is_rd_nxt || w_done_nxt;
    w_rclk_nxt   = (w_state_nxt == ST_RD_HIGH) || ((w_state_nxt == ST_RD_RRST) && w_hi_nxt);
    w_wrst_n_nxt = (w_state_nxt != ST_CAP_WRST);
    w_wen_nxt    = (w_state_nxt == ST_CAP_WAIT2);
    w_rrst_n_nxt = (w_state_nxt != ST_RD_RRST);
  end

  // FSM state and timing counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_half  <= {HW{1'b0}};
      r_hi    <= 1'b0;
      r_per   <= {PW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_half  <= w_half_nxt;
      r_hi    <= w_hi_nxt;
      r_per   <= w_per_nxt;
    end
  end

  // byte counter: cleared at the end of read reset, saturates at the frame size
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_byte_cnt <= {CW{1'b0}};
    end else if (w_rrst_end) begin
      r_byte_cnt <= {CW{1'b0}};
    end else if (w_dr_nxt && (r_byte_cnt != CNT_MAX)) begin
      r_byte_cnt <= r_byte_cnt + 1'b1;
    end else begin
      r_byte_cnt <= r_byte_cnt;
    end
  end

  // registered FIFO controls, status pulses and read data
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy       <= 1'b0;
      r_rrst_done  <= 1'b0;
      r_data_ready <= 1'b0;
      r_data       <= 8'h00;
      r_wrst_n     <= 1'b1;
      r_wen        <= 1'b0;
      r_rrst_n     <= 1'b1;
      r_rclk       <= 1'b0;
      r_oe_n       <= 1'b1;
    end else begin
      r_busy       <= w_busy_nxt;
      r_rrst_done  <= w_rrst_end;
      r_data_ready <= w_dr_nxt;
      r_wrst_n     <= w_wrst_n_nxt;
      r_wen        <= w_wen_nxt;
      r_rrst_n     <= w_rrst_n_nxt;
      r_rclk       <= w_rclk_nxt;
      r_oe_n       <= w_oe_n_nxt;
      if (w_data_cap) r_data <= i_fifo_d;
      else            r_data <= r_data;
    end
  end

  assign o_fifo_busy   = r_busy;
  assign o_rrst_done   = r_rrst_done;
  assign o_data_ready  = r_data_ready;
  assign o_data        = r_data;
  assign o_fifo_wrst_n = r_wrst_n;
  assign o_fifo_wen    = r_wen;
  assign o_fifo_rrst_n = r_rrst_n;
  assign o_fifo_rclk   = r_rclk;
  assign o_fifo_oe_n   = r_oe_n;

endmodule

// File: tb/tb_cam_fifo_ctrl.sv
// Directed self-checking bench for cam_fifo_ctrl with a 4-byte frame,
// RCLK_HALF=2 and RRST_CYCLES=2.
module tb_cam_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       capture_start, read_start, rd_byte_str, cam_vsync;
  logic [7:0] fifo_d;
  logic       fifo_busy, rrst_done, data_ready;
  logic [7:0] data;
  logic       wrst_n, wen, rrst_n, rclk, oe_n;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cam_fifo_ctrl #(.FRAME_BYTES(4), .RCLK_HALF(2), .RRST_CYCLES(2)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_capture_start (capture_start),
    .i_read_start    (read_start),
    .i_rd_byte_str   (rd_byte_str),
    .i_cam_vsync     (cam_vsync),
    .i_fifo_d        (fifo_d),
    .o_fifo_busy     (fifo_busy),
    .o_rrst_done     (rrst_done),
    .o_data_ready    (data_ready),
    .o_data          (data),
    .o_fifo_wrst_n   (wrst_n),
    .o_fifo_wen      (wen),
    .o_fifo_rrst_n   (rrst_n),
    .o_fifo_rclk     (rclk),
    .o_fifo_oe_n     (oe_n)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // busy,rrst_done,data_ready,data[7:0],wrst_n,wen,rrst_n,rclk,oe_n
  task automatic check_reset_vals(input string tag);
    check_val({tag, "_outs"},
              {16'h0, fifo_busy, rrst_done, data_ready, data, wrst_n, wen, rrst_n, rclk, oe_n},
              {16'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
  endtask

  // read_start, then sample 9 cycles: 2 RCLK periods under rrst_n=0, then rrst_done
  task automatic run_rrst(input string tag);
    logic [8:0] rclk_v, rrstn_v, done_v;
    read_start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      rclk_v[k-1]  = rclk;
      rrstn_v[k-1] = rrst_n;
      done_v[k-1]  = rrst_done;
      read_start   = 1'b0;
      rd_byte_str  = (k == 2);
    end
    rd_byte_str = 1'b0;
    check_val({tag, "_rclk_seq"},  {23'h0, rclk_v},  32'h033);
    check_val({tag, "_rrstn_seq"}, {23'h0, rrstn_v}, 32'h100);
    check_val({tag, "_done_seq"},  {23'h0, done_v},  32'h100);
    check_val({tag, "_oe_n"},      {31'h0, oe_n},    32'h0);
    check_val({tag, "_busy"},      {31'h0, fifo_busy}, 32'h1);
  endtask

  // one strobe from RD_WAIT; data only valid on the bus while RCLK is high
  task automatic read_byte(input string tag, input logic [7:0] d, input bit last, input bit abuse);
    int lat = 0;
    bit seen = 1'b0;
    rd_byte_str = 1'b1;
    fifo_d      = d;
    for (int c = 1; c <= 8 && !seen; c++) begin
      tick();
      rd_byte_str = (c == 1) && abuse;
      if (c == 1) check_val({tag, "_rrst_done_low"}, {31'h0, rrst_done}, 32'h0);
      if (c == 3) fifo_d = 8'hEE;
      if (data_ready) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    rd_byte_str = 1'b0;
    check_val({tag, "_latency"}, lat, 32'd4);
    check_val({tag, "_data"}, {24'h0, data}, {24'h0, d});
    check_val({tag, "_busy"}, {31'h0, fifo_busy}, {31'h0, !last});
    check_val({tag, "_oe_n"}, {31'h0, oe_n}, {31'h0, last});
    tick();
    check_val({tag, "_dr_pulse"}, {31'h0, data_ready}, 32'h0);
  endtask

  // n idle cycles: no pulses, no RCLK, not busy
  task automatic quiet(input string tag, input int n);
    int act = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (data_ready || rrst_done || fifo_busy || rclk || !rrst_n) act++;
    end
    check_val({tag, "_quiet"}, act, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int first_wrst, n_wrst, first_wen, n_wen, first_idle, n_rrst_low, n_oe_low, busy_at1;
    logic wen_at_idle;
    rst = 1'b1; capture_start = 1'b0; read_start = 1'b0;
    rd_byte_str = 1'b0; cam_vsync = 1'b0; fifo_d = 8'h00;
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();
    check_reset_vals("idle");

    // capture with a simultaneous read request, plus a read request mid-capture
    first_wrst = 0; n_wrst = 0; first_wen = 0; n_wen = 0; first_idle = 0;
    n_rrst_low = 0; n_oe_low = 0; busy_at1 = 0; wen_at_idle = 1'b1;
    capture_start = 1'b1;
    read_start    = 1'b1;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      tick();
      if (cyc == 1) busy_at1 = fifo_busy;
      if (!wrst_n) begin
        n_wrst++;
        if (first_wrst == 0) first_wrst = cyc;
      end
      if (wen) begin
        n_wen++;
        if (first_wen == 0) first_wen = cyc;
      end
      if (!fifo_busy && first_idle == 0) begin
        first_idle  = cyc;
        wen_at_idle = wen;
      end
      if (!rrst_n) n_rrst_low++;
      if (!oe_n) n_oe_low++;
      capture_start = 1'b0;
      read_start    = (cyc == 30);
      cam_vsync     = (cyc <= 10) || (cyc >= 61);
    end
    read_start = 1'b0;
    check_val("cap_busy_start", busy_at1, 32'd1);
    check_val("cap_wrst_first", first_wrst, 32'd4);
    check_val("cap_wrst_len", n_wrst, 32'd10);
    check_val("cap_wen_first", first_wen, 32'd14);
    check_val("cap_wen_len", n_wen, 32'd50);
    check_val("cap_busy_fall", first_idle, 32'd64);
    check_val("cap_wen_at_fall", {31'h0, wen_at_idle}, 32'd0);
    check_val("cap_rrst_never", n_rrst_low, 32'd0);
    check_val("cap_oe_never", n_oe_low, 32'd0);
    check_reset_vals("cap_done");

    // full readout, with stray strobes in RD_RRST and RD_HIGH
    run_rrst("rd1");
    read_byte("rd1_b0", 8'hA1, 1'b0, 1'b0);
    read_byte("rd1_b1", 8'hB2, 1'b0, 1'b1);
    read_byte("rd1_b2", 8'hC3, 1'b0, 1'b0);
    read_byte("rd1_b3", 8'hD4, 1'b1, 1'b0);
    quiet("rd1_end", 6);

    // re-read, abort with reset during the third byte, then read again from byte 0
    run_rrst("rd2");
    read_byte("rd2_b0", 8'hA1, 1'b0, 1'b0);
    read_byte("rd2_b1", 8'hB2, 1'b0, 1'b0);
    rd_byte_str = 1'b1;
    fifo_d      = 8'hC3;
    tick();
    rd_byte_str = 1'b0;
    rst = 1'b1;
    tick();
    check_reset_vals("abort");
    rst = 1'b0;
    quiet("abort", 8);
    check_val("abort_data", {24'h0, data}, 32'h0);

    run_rrst("rd3");
    read_byte("rd3_b0", 8'h5A, 1'b0, 1'b0);
    read_byte("rd3_b1", 8'h6B, 1'b0, 1'b0);
    read_byte("rd3_b2", 8'h7C, 1'b0, 1'b0);
    read_byte("rd3_b3", 8'h8D, 1'b1, 1'b0);
    quiet("rd3_end", 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
